memory_game_sm: RTL

//  Game-state engine for the 4x4 memory test; drives the VGA renderer's board inputs.

---
 rtl/memory_game_pkg.sv | 42 ++++
 rtl/memory_lfsr16.sv | 22 ++
 rtl/memory_game_sm.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the 4x4 memory game engine.
// State encoding, grid geometry, LFSR taps and flag decode.
package memory_game_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        GEN   = 3'd1,
        FLASH = 3'd2,
        PLAY  = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    localparam int GRID_DIM = 4;

    // Taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] idx(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {row, col};
    endfunction

    // Flag order: {Qi, Qfo, Qp, Qg, Ql}; GEN still shows Qi
    function automatic logic [4:0] flags_of(input state_t s);
        logic [4:0] f;
        f = 5'b10000;
        case (s)
            INIT:    f = 5'b10000;
            GEN:     f = 5'b10000;
            FLASH:   f = 5'b01000;
            PLAY:    f = 5'b00100;
            WIN:     f = 5'b00010;
            LOSE:    f = 5'b00001;
            default: f = 5'b10000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/memory_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick target squares.
// Shifts left every cycle; feedback is the XOR of the tapped bits.
module memory_lfsr16
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    // Advance one step per clock, reload the seed on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/memory_game_sm.sv
// Game-state engine for the 4x4 memory test.
// Generates a pattern, flashes it, then tracks cursor and guesses.
module memory_game_sm
    import memory_game_pkg::*;
#(
    parameter int          NUM_TARGETS  = 4,
    parameter logic [31:0] FLASH_CYCLES = 32'd200_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] B0,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic [1:0] X,
    output logic [1:0] Y,
    output logic       Qi,
    output logic       Qfo,
    output logic       Qp,
    output logic       Qg,
    output logic       Ql
);

    // A zero target count would never leave GEN usefully
    localparam logic [3:0] NT =
        (NUM_TARGETS == 0) ? 4'd1 : 4'(NUM_TARGETS);

    state_t      state;
    logic [4:0]  flags;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  hit_cnt;
    logic [3:0]  gen_cnt;
    logic [31:0] flash_cnt;
    logic [15:0] lfsr;
    logic [3:0]  gi;
    logic [3:0]  ci;

    memory_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr)
    );

    assign gi = lfsr[3:0];
    assign ci = idx(X, Y);

    assign {A3, A2, A1, A0} = a;
    assign {B3, B2, B1, B0} = b;
    assign {Qi, Qfo, Qp, Qg, Ql} = flags;

    // Game FSM with registered board, cursor and state flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            flags     <= flags_of(INIT);
            a         <= '0;
            b         <= '0;
            X         <= '0;
            Y         <= '0;
            hit_cnt   <= '0;
            gen_cnt   <= '0;
            flash_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    a       <= '0;
                    b       <= '0;
                    X       <= '0;
                    Y       <= '0;
                    gen_cnt <= '0;
                    hit_cnt <= '0;
                    if (btnC) begin
                        state <= GEN;
                        flags <= flags_of(GEN);
                    end
                end
                GEN: begin
                    if (gen_cnt == NT) begin
                        state     <= FLASH;
                        flags     <= flags_of(FLASH);
                        flash_cnt <= '0;
                    end else if (!a[gi]) begin
                        a[gi]   <= 1'b1;
                        gen_cnt <= gen_cnt + 4'd1;
                    end
                end
                FLASH: begin
                    if (flash_cnt == FLASH_CYCLES - 32'd1) begin
                        state <= PLAY;
                        flags <= flags_of(PLAY);
                    end else begin
                        flash_cnt <= flash_cnt + 32'd1;
                    end
                end
                PLAY: begin
                    if (btnC) begin
                        if (!b[ci]) begin
                            b[ci] <= 1'b1;
                            if (a[ci]) begin
                                hit_cnt <= hit_cnt + 4'd1;
                                if (hit_cnt + 4'd1 == NT) begin
                                    state <= WIN;
                                    flags <= flags_of(WIN);
                                end
                            end else begin
                                state <= LOSE;
                                flags <= flags_of(LOSE);
                            end
                        end
                    end else begin
                        case ({btnU, btnD})
                            2'b10:   X <= X - 2'd1;
                            2'b01:   X <= X + 2'd1;
                            default: ;
                        endcase
                        case ({btnL, btnR})
                            2'b10:   Y <= Y - 2'd1;
                            2'b01:   Y <= Y + 2'd1;
                            default: ;
                        endcase
                    end
                end
                WIN, LOSE: begin
                    // Clear on the way out so INIT shows an empty board at once
                    if (btnC) begin
                        state   <= INIT;
                        flags   <= flags_of(INIT);
                        a       <= '0;
                        b       <= '0;
                        X       <= '0;
                        Y       <= '0;
                        hit_cnt <= '0;
                        gen_cnt <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    flags <= flags_of(INIT);
                end
            endcase
        end
    end

endmodule
